// File: rtl/window_gen_3x3_param.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers supply the rows above the current pixel, and column shift
// registers supply the two columns to its left. Each accepted pixel produces
// one registered window. Missing edge taps are cropped, zero-filled or
// replicated, as selected by BORDER.
module window_gen_3x3_param #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int BORDER = 0
) (
    input  logic                       sclk,
    input  logic                       s_rst_n,
    input  logic                       frame_start,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [9*DATA_W-1:0]        out_win,
    output logic [$clog2(IMG_W)-1:0]   out_x,
    output logic [$clog2(IMG_H)-1:0]   out_y,
    output logic                       out_eol,
    output logic                       out_eof
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]     x_reg, x_next, cur_x;
    logic [YW-1:0]     y_reg, y_next, cur_y;
    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] col_new [3];
    logic [DATA_W-1:0] raw_reg [9];
    logic [DATA_W-1:0] raw_next [9];
    logic [DATA_W-1:0] tap_next [9];
    logic [DATA_W-1:0] win_reg [9];
    logic [1:0]        col_lo, row_lo;
    logic              emit;
    logic              out_valid_reg, out_eol_reg, out_eof_reg;
    logic [XW-1:0]     out_x_reg;
    logic [YW-1:0]     out_y_reg;

    // Work out the position of this cycle's pixel (frame_start forces it to
    // the origin), then advance the counters with line and frame wrap.
    always_comb begin
        cur_x  = frame_start ? '0 : x_reg;
        cur_y  = frame_start ? '0 : y_reg;
        x_next = x_reg;
        y_next = y_reg;
        if (in_valid) begin
            if (cur_x == X_LAST) begin
                x_next = '0;
                y_next = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
            end else begin
                x_next = cur_x + XW'(1);
                y_next = cur_y;
            end
        end else if (frame_start) begin
            x_next = '0;
            y_next = '0;
        end
    end

    // Position counters.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    // Line buffers, read before write: each pixel moves one line further up.
    // The RAM contents are not reset.
    always_ff @(posedge sclk) begin
        if (in_valid) begin
            lb1_mem[cur_x] <= lb0_mem[cur_x];
            lb0_mem[cur_x] <= in_data;
        end
    end

    // Build the incoming column and shift the raw window one column left.
    always_comb begin
        col_new[0] = lb1_mem[cur_x];
        col_new[1] = lb0_mem[cur_x];
        col_new[2] = in_data;
        for (int r = 0; r < 3; r++) begin
            raw_next[r*3]     = raw_reg[r*3+1];
            raw_next[r*3 + 1] = raw_reg[r*3+2];
            raw_next[r*3 + 2] = col_new[r];
        end
    end

    // Raw, unmasked window. It advances only on accepted pixels.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < 9; i++) raw_reg[i] <= '0;
        end else if (in_valid) begin
            for (int i = 0; i < 9; i++) raw_reg[i] <= raw_next[i];
        end
    end

    // Find the lowest window row and column that hold real pixels of this frame.
    always_comb begin
        col_lo = (cur_x == '0) ? 2'd2 : (cur_x == XW'(1)) ? 2'd1 : 2'd0;
        row_lo = (cur_y == '0) ? 2'd2 : (cur_y == YW'(1)) ? 2'd1 : 2'd0;
    end

    // Per-tap edge handling. A tap outside the frame never passes through
    // stale buffer contents.
    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        localparam logic [1:0] R = 2'(gi / 3);
        localparam logic [1:0] C = 2'(gi % 3);
        if (BORDER == 1) begin : g_zero
            assign tap_next[gi] = (R < row_lo || C < col_lo) ? '0 : raw_next[gi];
        end else if (BORDER == 2) begin : g_rep
            logic [1:0] src_r, src_c;
            logic [3:0] src_idx;
            assign src_r   = (R < row_lo) ? row_lo : R;
            assign src_c   = (C < col_lo) ? col_lo : C;
            assign src_idx = 4'(src_r) * 4'd3 + 4'(src_c);
            assign tap_next[gi] = raw_next[src_idx];
        end else begin : g_crop
            assign tap_next[gi] = raw_next[gi];
        end
        assign out_win[(8-gi)*DATA_W +: DATA_W] = win_reg[gi];
    end

    assign emit = in_valid &&
                  ((BORDER != 0) || (cur_x >= XW'(2) && cur_y >= YW'(2)));

    // Output registers. The window and position hold between emitted outputs.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < 9; i++) win_reg[i] <= '0;
            out_valid_reg <= 1'b0;
            out_eol_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
        end else begin
            out_valid_reg <= emit;
            out_eol_reg   <= emit && (cur_x == X_LAST);
            out_eof_reg   <= emit && (cur_x == X_LAST) && (cur_y == Y_LAST);
            if (emit) begin
                for (int i = 0; i < 9; i++) win_reg[i] <= tap_next[i];
                out_x_reg <= cur_x;
                out_y_reg <= cur_y;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_x     = out_x_reg;
    assign out_y     = out_y_reg;
    assign out_eol   = out_eol_reg;
    assign out_eof   = out_eof_reg;
endmodule

// File: tb/tb_window_gen_3x3_param.sv
// Directed bench for window_gen_3x3_param on an 8x4 frame. Three instances
// share one stimulus: crop (0), zero-pad (1) and replicate (2).
module tb_window_gen_3x3_param;
    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic        frame_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        vld [3];
    logic [71:0] win [3];
    logic [2:0]  ox  [3];
    logic [1:0]  oy  [3];
    logic        eol [3];
    logic        eof [3];

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        window_gen_3x3_param #(
            .DATA_W(8), .IMG_W(8), .IMG_H(4), .BORDER(gi)
        ) u_dut (
            .sclk(sclk), .s_rst_n(s_rst_n), .frame_start(frame_start),
            .in_valid(in_valid), .in_data(in_data),
            .out_valid(vld[gi]), .out_win(win[gi]), .out_x(ox[gi]),
            .out_y(oy[gi]), .out_eol(eol[gi]), .out_eof(eof[gi])
        );
    end

    // Reference window, built from the definition: pixel(x,y) = base + y*8 + x.
    function automatic logic [71:0] exp_win(int border, int x, int y, int base);
        logic [71:0] w;
        logic [7:0]  p;
        int xx, yy;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                yy = y - (2 - r);
                xx = x - (2 - c);
                if (border == 2) begin
                    if (xx < 0) xx = 0;
                    if (yy < 0) yy = 0;
                    p = 8'(base + yy*8 + xx);
                end else if (xx < 0 || yy < 0) begin
                    p = 8'd0;
                end else begin
                    p = 8'(base + yy*8 + xx);
                end
                w = {w[63:0], p};
            end
        end
        return w;
    endfunction

    task automatic send(input logic [7:0] d, input logic fs);
        in_valid    = 1'b1;
        in_data     = d;
        frame_start = fs;
        @(posedge sclk); #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle();
        @(posedge sclk); #1;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; in_data = '0;
        repeat (3) @(posedge sclk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld[k] !== 1'b0 || win[k] !== 72'd0 || ox[k] !== 3'd0 ||
                oy[k] !== 2'd0 || eol[k] !== 1'b0 || eof[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got vld=%b win=%h x=%0d y=%0d eol=%b eof=%b, expected all 0",
                         k, vld[k], win[k], ox[k], oy[k], eol[k], eof[k]);
            end
        end
        s_rst_n = 1'b1;
        idle();
    endtask

    task automatic test_crop();
        int cnt = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                send(8'(y*8 + x), x == 0 && y == 0);
                checks++;
                if (vld[0] !== (x >= 2 && y >= 2) || eol[0] !== (x == 7 && y >= 2)) begin
                    errors++;
                    $display("FAIL crop_valid (%0d,%0d): got vld=%b eol=%b", x, y, vld[0], eol[0]);
                end
                if (vld[0]) begin
                    cnt++;
                    checks++;
                    if (win[0] !== exp_win(0, x, y, 0) || ox[0] !== 3'(x) || oy[0] !== 2'(y)) begin
                        errors++;
                        $display("FAIL crop_win (%0d,%0d): got %h at (%0d,%0d), expected %h",
                                 x, y, win[0], ox[0], oy[0], exp_win(0, x, y, 0));
                    end
                end
                if (x == 2 && y == 2) begin
                    checks++;
                    if (win[0] !== {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18}) begin
                        errors++;
                        $display("FAIL crop_2_2: got %h expected 00010208090a101112", win[0]);
                    end
                end
            end
        end
        checks++;
        if (cnt != 12) begin
            errors++;
            $display("FAIL crop_count: got %0d expected 12", cnt);
        end
    endtask

    task automatic test_zero_pad();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                send(8'(y*8 + x), x == 0 && y == 0);
                checks++;
                if (vld[1] !== 1'b1 || win[1] !== exp_win(1, x, y, 0)) begin
                    errors++;
                    $display("FAIL zero_win (%0d,%0d): got vld=%b %h expected 1 %h",
                             x, y, vld[1], win[1], exp_win(1, x, y, 0));
                end
                if (x == 0 && y == 0) begin
                    checks++;
                    if (win[1] !== 72'd0) begin
                        errors++;
                        $display("FAIL zero_0_0: got %h expected 0", win[1]);
                    end
                end
                if (x == 1 && y == 1) begin
                    checks++;
                    if (win[1] !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd8, 8'd9}) begin
                        errors++;
                        $display("FAIL zero_1_1: got %h expected 000000000001000809", win[1]);
                    end
                end
            end
        end
    endtask

    task automatic test_replicate();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                send(8'(y*8 + x), x == 0 && y == 0);
                checks++;
                if (vld[2] !== 1'b1 || win[2] !== exp_win(2, x, y, 0)) begin
                    errors++;
                    $display("FAIL rep_win (%0d,%0d): got vld=%b %h expected 1 %h",
                             x, y, vld[2], win[2], exp_win(2, x, y, 0));
                end
                if (x == 0 && y == 0) begin
                    checks++;
                    if (win[2] !== 72'd0) begin
                        errors++;
                        $display("FAIL rep_0_0: got %h expected 0", win[2]);
                    end
                end
                if (x == 1 && y == 0) begin
                    checks++;
                    if (win[2] !== {3{8'd0, 8'd0, 8'd1}}) begin
                        errors++;
                        $display("FAIL rep_1_0: got %h expected 000001000001000001", win[2]);
                    end
                end
                if (x == 0 && y == 1) begin
                    checks++;
                    if (win[2] !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd8, 8'd8}) begin
                        errors++;
                        $display("FAIL rep_0_1: got %h expected 000000000000080808", win[2]);
                    end
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [71:0] last [3];
        logic [71:0] e;
        logic        ev;
        for (int k = 0; k < 3; k++) last[k] = exp_win(k, 7, 3, 0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                if ($urandom_range(1) == 1) begin
                    int n;
                    n = $urandom_range(2, 1);
                    repeat (n) begin
                        idle();
                        for (int k = 0; k < 3; k++) begin
                            checks++;
                            if (vld[k] !== 1'b0 || win[k] !== last[k]) begin
                                errors++;
                                $display("FAIL gap_hold[%0d] (%0d,%0d): got vld=%b %h expected 0 %h",
                                         k, x, y, vld[k], win[k], last[k]);
                            end
                        end
                    end
                end
                send(8'(50 + y*8 + x), x == 0 && y == 0);
                for (int k = 0; k < 3; k++) begin
                    ev = (k != 0) || (x >= 2 && y >= 2);
                    checks++;
                    if (vld[k] !== ev) begin
                        errors++;
                        $display("FAIL gap_valid[%0d] (%0d,%0d): got %b expected %b", k, x, y, vld[k], ev);
                    end
                    if (ev) begin
                        e = exp_win(k, x, y, 50);
                        checks++;
                        if (win[k] !== e) begin
                            errors++;
                            $display("FAIL gap_win[%0d] (%0d,%0d): got %h expected %h", k, x, y, win[k], e);
                        end
                        last[k] = e;
                    end
                end
            end
        end
    endtask

    task automatic test_frame_start();
        int cnt = 0;
        // Abandon the frame where (3,2) would have been accepted.
        for (int i = 0; i < 19; i++) send(8'(i), i == 0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                send(8'(200 + y*8 + x), x == 0 && y == 0);
                checks++;
                if (ox[1] !== 3'(x) || oy[1] !== 2'(y) || win[1] !== exp_win(1, x, y, 200)) begin
                    errors++;
                    $display("FAIL resync_zero (%0d,%0d): got (%0d,%0d) %h expected %h",
                             x, y, ox[1], oy[1], win[1], exp_win(1, x, y, 200));
                end
                checks++;
                if (vld[0] !== (x >= 2 && y >= 2)) begin
                    errors++;
                    $display("FAIL resync_crop_valid (%0d,%0d): got %b", x, y, vld[0]);
                end
                if (vld[0]) begin
                    cnt++;
                    checks++;
                    if (win[0] !== exp_win(0, x, y, 200)) begin
                        errors++;
                        $display("FAIL resync_crop_win (%0d,%0d): got %h expected %h",
                                 x, y, win[0], exp_win(0, x, y, 200));
                    end
                end
            end
        end
        checks++;
        if (cnt != 12) begin
            errors++;
            $display("FAIL resync_crop_count: got %0d expected 12", cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n_eol, n_eof;
        for (int f = 0; f < 2; f++) begin
            n_eol = 0;
            n_eof = 0;
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 8; x++) begin
                    send(8'(f*100 + y*8 + x), 1'b0);
                    if (eol[1]) n_eol++;
                    if (eof[1]) n_eof++;
                    checks++;
                    if (win[2] !== exp_win(2, x, y, f*100) || eof[1] !== (x == 7 && y == 3)) begin
                        errors++;
                        $display("FAIL b2b_rep f%0d (%0d,%0d): got %h eof=%b expected %h",
                                 f, x, y, win[2], eof[1], exp_win(2, x, y, f*100));
                    end
                end
            end
            checks++;
            if (n_eol != 4 || n_eof != 1) begin
                errors++;
                $display("FAIL b2b_flags f%0d: got eol=%0d eof=%0d expected 4 1", f, n_eol, n_eof);
            end
        end
        // Reset asserted in the middle of a line, away from any clock edge.
        for (int x = 0; x < 3; x++) send(8'(x + 1), 1'b0);
        #3;
        s_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vld[k] !== 1'b0 || win[k] !== 72'd0 || ox[k] !== 3'd0 ||
                oy[k] !== 2'd0 || eol[k] !== 1'b0 || eof[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset[%0d]: got vld=%b win=%h x=%0d y=%0d", k, vld[k], win[k], ox[k], oy[k]);
            end
        end
        @(posedge sclk); #1;
        s_rst_n = 1'b1;
        send(8'd77, 1'b0);
        checks++;
        if (vld[1] !== 1'b1 || ox[1] !== 3'd0 || oy[1] !== 2'd0 || win[1] !== {64'd0, 8'd77}) begin
            errors++;
            $display("FAIL post_reset_zero: got vld=%b (%0d,%0d) %h expected (0,0) ...4d",
                     vld[1], ox[1], oy[1], win[1]);
        end
        checks++;
        if (win[2] !== {9{8'd77}} || vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rep: got %h crop_vld=%b expected all 4d, 0", win[2], vld[0]);
        end
    endtask

    initial begin
        test_reset();
        test_crop();
        test_zero_pad();
        test_replicate();
        test_gaps();
        test_frame_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
